// File: rtl/spram_1024x8_fifo_ctrl.sv
// Valid/ready FIFO controller that drives a single-port 1024x8 RAM and hides its read latency
// behind a 2-entry output buffer. Define SPRAM_FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty.
module spram_1024x8_fifo_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
`ifdef SPRAM_FIFO_ALMOST_FLAGS_EN
   ,
   parameter int AF_THRESH = 1020,
   parameter int AE_THRESH = 2
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_valid,
   output logic              push_ready,
   input  logic [DATA_W-1:0] push_data,
   output logic              pop_valid,
   input  logic              pop_ready,
   output logic [DATA_W-1:0] pop_data,
   output logic [ADDR_W:0]   level,
`ifdef SPRAM_FIFO_ALMOST_FLAGS_EN
   output logic              almost_full,
   output logic              almost_empty,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_d_in,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_d_out
);

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
   logic [1:0]        ob_cnt_q, ob_cnt_d;
   logic              rd_inflight_q, rd_inflight_d;
   logic [DATA_W-1:0] obuf0_q, obuf0_d, obuf1_q, obuf1_d;
   logic              rd_req, urgent, do_wr, do_rd, do_pop, append;

   always_comb begin
      rd_req     = (ram_cnt_q != '0) &&
                   ((ob_cnt_q == 2'd0) || ((ob_cnt_q == 2'd1) && !rd_inflight_q));
      // Nothing buffered and nothing arriving: the read must win the port over a push.
      urgent     = rd_req && (ob_cnt_q == 2'd0) && !rd_inflight_q;
      push_ready = !reset && !urgent && (ram_cnt_q != DEPTH_C);
      do_wr      = push_valid && push_ready;
      do_rd      = !reset && !do_wr && rd_req;
      pop_valid  = !reset && (ob_cnt_q != 2'd0);
      pop_data   = obuf0_q;
      do_pop     = pop_valid && pop_ready;
      append     = rd_inflight_q;

      mem_wen    = do_wr;
      mem_addr   = do_wr ? wr_ptr_q : rd_ptr_q;
      mem_d_in   = push_data;

      wr_ptr_d      = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d      = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rd_inflight_d = do_rd;
      case ({do_wr, do_rd})
         2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
         2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
         default: ram_cnt_d = ram_cnt_q;
      endcase
      case ({append, do_pop})
         2'b10:   ob_cnt_d = ob_cnt_q + 2'd1;
         2'b01:   ob_cnt_d = ob_cnt_q - 2'd1;
         default: ob_cnt_d = ob_cnt_q;
      endcase

      obuf0_d = obuf0_q;
      obuf1_d = obuf1_q;
      if (do_pop) obuf0_d = obuf1_q;
      // Append lands in the first slot left free after any same-cycle pop.
      if (append) begin
         if ((ob_cnt_q == 2'd0) || ((ob_cnt_q == 2'd1) && do_pop)) obuf0_d = mem_d_out;
         else obuf1_d = mem_d_out;
      end

      level = reset ? '0 : ram_cnt_q + {{(ADDR_W-1){1'b0}}, ob_cnt_q}
                                     + {{ADDR_W{1'b0}}, rd_inflight_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ram_cnt_q     <= '0;
         ob_cnt_q      <= '0;
         rd_inflight_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ram_cnt_q     <= ram_cnt_d;
         ob_cnt_q      <= ob_cnt_d;
         rd_inflight_q <= rd_inflight_d;
      end
   end

   always_ff @(posedge clk) begin
      obuf0_q <= obuf0_d;
      obuf1_q <= obuf1_d;
   end

`ifdef SPRAM_FIFO_ALMOST_FLAGS_EN
   logic [ADDR_W:0] level_d;
   logic            almost_full_q, almost_empty_q;

   // Flags come from next-state counts so they line up with level in the same cycle.
   assign level_d = ram_cnt_d + {{(ADDR_W-1){1'b0}}, ob_cnt_d}
                              + {{ADDR_W{1'b0}}, rd_inflight_d};

   always_ff @(posedge clk) begin
      if (reset) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= (level_d >= (ADDR_W+1)'(AF_THRESH));
         almost_empty_q <= (level_d <= (ADDR_W+1)'(AE_THRESH));
      end
   end

   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_spram_1024x8_fifo_ctrl.sv
// Bench for spram_1024x8_fifo_ctrl: RAM model plus queue scoreboard checking order, level and handshakes.
module tb_spram_1024x8_fifo_ctrl;

   logic        clk, reset;
   logic        push_valid, push_ready, pop_valid, pop_ready;
   logic [7:0]  push_data, pop_data;
   logic [10:0] level;
   logic [9:0]  mem_addr;
   logic [7:0]  mem_d_in, mem_d_out;
   logic        mem_wen;
`ifdef SPRAM_FIFO_ALMOST_FLAGS_EN
   logic        almost_full, almost_empty;
`endif

   spram_1024x8_fifo_ctrl dut (
      .clk(clk), .reset(reset),
      .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
      .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
      .level(level),
`ifdef SPRAM_FIFO_ALMOST_FLAGS_EN
      .almost_full(almost_full), .almost_empty(almost_empty),
`endif
      .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_wen(mem_wen), .mem_d_out(mem_d_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // single-port RAM primitive; output after a write is scrambled garbage
   logic [7:0] ram [0:1023];
   logic [7:0] ram_q;
   always @(posedge clk) begin
      if (mem_wen) begin
         ram[mem_addr] <= mem_d_in;
         ram_q         <= mem_d_in ^ 8'h5A;
      end else begin
         ram_q <= ram[mem_addr];
      end
   end
   assign mem_d_out = ram_q;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] sb_q[$];
   int n_pop = 0;

   logic        s_push_ready, s_pop_valid, s_mem_wen;
   logic [7:0]  s_pop_data;
   logic [10:0] s_level;
   logic [9:0]  s_mem_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs are set at the falling edge; sample 1ns later, score the handshakes
   // that the next rising edge will perform, then wait for the next falling edge.
   task automatic step();
      logic [7:0] exp_d;
      #1;
      s_push_ready = push_ready;
      s_pop_valid  = pop_valid;
      s_pop_data   = pop_data;
      s_level      = level;
      s_mem_wen    = mem_wen;
      s_mem_addr   = mem_addr;
      if (reset) begin
         sb_q.delete();
      end else begin
         chk("level", 32'(s_level), 32'(sb_q.size()));
`ifdef SPRAM_FIFO_ALMOST_FLAGS_EN
         chk("almost_full", 32'(almost_full), 32'(sb_q.size() >= 1020));
         chk("almost_empty", 32'(almost_empty), 32'(sb_q.size() <= 2));
`endif
         if (push_valid && s_push_ready) sb_q.push_back(push_data);
         if (s_pop_valid && pop_ready) begin
            n_pop++;
            if (sb_q.size() == 0) chk("underflow", 32'd1, 32'd0);
            else begin
               exp_d = sb_q.pop_front();
               chk("pop_data", 32'(s_pop_data), 32'(exp_d));
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int n_fill, n_acc, wraps, cyc, win_pop, win_push, pop0;
      logic prev_low;

      reset = 1'b1; push_valid = 1'b1; push_data = 8'h11; pop_ready = 1'b1;
      @(negedge clk);
      step();
      step();
      chk("rst_pop_valid", 32'(s_pop_valid), 0);
      chk("rst_level", 32'(s_level), 0);
      chk("rst_mem_wen", 32'(s_mem_wen), 0);
      chk("rst_push_ready", 32'(s_push_ready), 0);

      // single push into empty FIFO: latency profile
      reset = 1'b0; push_valid = 1'b1; push_data = 8'hA5; pop_ready = 1'b0;
      step();
      chk("a_c0_wen", 32'(s_mem_wen), 1);
      chk("a_c0_addr", 32'(s_mem_addr), 0);
      chk("a_c0_ready", 32'(s_push_ready), 1);
      push_valid = 1'b0;
      step();
      chk("a_c1_wen", 32'(s_mem_wen), 0);
      chk("a_c1_addr", 32'(s_mem_addr), 0);
      chk("a_c1_ready", 32'(s_push_ready), 0);
      step();
      chk("a_c2_pop_valid", 32'(s_pop_valid), 0);
      chk("a_c2_level", 32'(s_level), 1);
      step();
      chk("a_c3_pop_valid", 32'(s_pop_valid), 1);
      chk("a_c3_pop_data", 32'(s_pop_data), 32'h A5);
      pop_ready = 1'b1;
      step();
      pop_ready = 1'b0;
      step();
      chk("a_empty_pop_valid", 32'(s_pop_valid), 0);

      // fill to capacity with pops blocked
      n_fill = 0; push_valid = 1'b1; push_data = 8'h00;
      for (int i = 0; i < 2200; i++) begin
         step();
         if (s_push_ready) n_fill++;
         push_data = 8'(n_fill);
      end
      chk("fill_count", 32'(n_fill), 1026);
      chk("full_push_ready", 32'(s_push_ready), 0);
      chk("full_level", 32'(s_level), 1026);

      // streaming from full with both sides always willing
      pop_ready = 1'b1; win_pop = 0; win_push = 0; prev_low = 1'b0;
      for (int i = 0; i < 400; i++) begin
         step();
         chk("pop_gap", 32'(s_level >= 3 && !s_pop_valid && prev_low), 0);
         prev_low = !s_pop_valid;
         if (i >= 100) begin
            if (s_pop_valid) win_pop++;
            if (s_push_ready) win_push++;
         end
         if (s_push_ready) n_fill++;
         push_data = 8'(n_fill);
      end
      chk("stream_pop_tput", 32'(win_pop * 2 + 2 >= 300), 1);
      chk("stream_push_tput", 32'(win_push * 2 + 2 >= 300), 1);

      // drain everything
      push_valid = 1'b0; cyc = 0;
      while (sb_q.size() > 0 && cyc < 4000) begin
         step();
         cyc++;
      end
      chk("drain_done", 32'(sb_q.size()), 0);
      step();
      step();
      chk("drain_pop_valid", 32'(s_pop_valid), 0);
      chk("drain_level", 32'(s_level), 0);

      // random traffic, 5000 items
      n_acc = 0; wraps = 0; cyc = 0;
      while ((n_acc < 5000 || sb_q.size() > 0) && cyc < 40000) begin
         push_valid = (n_acc < 5000) ? 1'($urandom_range(0, 1)) : 1'b0;
         push_data  = 8'($urandom);
         pop_ready  = 1'($urandom_range(0, 1));
         step();
         if (push_valid && s_push_ready) n_acc++;
         if (s_mem_wen && s_mem_addr == 10'd1023) wraps++;
         cyc++;
      end
      chk("rand_accepted", 32'(n_acc), 5000);
      chk("rand_drained", 32'(sb_q.size()), 0);
      chk("rand_wraps", 32'(wraps >= 4), 1);

      // reset while a read is in flight
      push_valid = 1'b1; pop_ready = 1'b0; n_acc = 0; cyc = 0;
      while (n_acc < 10 && cyc < 100) begin
         push_data = 8'(8'h80 + n_acc);
         step();
         if (s_push_ready) n_acc++;
         cyc++;
      end
      chk("d_pushed", 32'(n_acc), 10);
      push_valid = 1'b0;
      step();
      chk("d_pop_valid", 32'(s_pop_valid), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("d_post_pop_valid", 32'(s_pop_valid), 0);
      chk("d_post_level", 32'(s_level), 0);
      push_valid = 1'b1; push_data = 8'h3C; pop_ready = 1'b1;
      step();
      chk("d_3c_accepted", 32'(s_push_ready), 1);
      push_valid = 1'b0; pop0 = n_pop; cyc = 0;
      while (n_pop == pop0 && cyc < 10) begin
         step();
         cyc++;
      end
      chk("d_3c_popped", 32'(n_pop - pop0), 1);
      step();
      step();
      chk("d_end_pop_valid", 32'(s_pop_valid), 0);
      chk("d_end_level", 32'(s_level), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
